// File: rtl/noc_local_ni.sv
// rtl/noc_local_ni.sv - local-port network interface: core<->router flit FIFOs in both directions
// Optional RX address filtering with drop counter is enabled by defining NI_RX_ADDR_CHECK_EN.

module noc_local_ni_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;

  // Flags come from the registered count only, so ready never depends on the far side's ready.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + P_ONE;
      if (pop)  rptr <= rptr + P_ONE;
      if (push && !pop)      count <= count + C_ONE;
      else if (pop && !push) count <= count - C_ONE;
    end
  end
endmodule

module noc_local_ni #(
  parameter logic [1:0] MY_X     = 2'd1,
  parameter logic [1:0] MY_Y     = 2'd1,
  parameter int         TX_DEPTH = 4,
  parameter int         RX_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                tx_dest_x,
  input  logic [1:0]                tx_dest_y,
  input  logic [3:0]                tx_payload,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                flit_out,
  output logic                      flit_valid_out,
  input  logic                      flit_ready_in,
  input  logic [7:0]                flit_in,
  input  logic                      flit_valid_in,
  output logic                      flit_ready_out,
  output logic [3:0]                rx_payload,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count
`ifdef NI_RX_ADDR_CHECK_EN
  ,
  output logic [7:0]                drop_count,
  output logic                      err_misroute
`endif
);
  logic addr_ok;

  noc_local_ni_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({tx_dest_x, tx_dest_y, tx_payload}),
    .in_valid  (tx_valid),
    .in_ready  (tx_ready),
    .out_data  (flit_out),
    .out_valid (flit_valid_out),
    .out_ready (flit_ready_in),
    .count     (tx_count)
  );

  // A filtered flit is still handshaken; it just never reaches the FIFO write port.
  noc_local_ni_fifo #(.W(4), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (flit_in[3:0]),
    .in_valid  (flit_valid_in && addr_ok),
    .in_ready  (flit_ready_out),
    .out_data  (rx_payload),
    .out_valid (rx_valid),
    .out_ready (rx_ready),
    .count     (rx_count)
  );

`ifdef NI_RX_ADDR_CHECK_EN
  logic misroute;

  assign addr_ok  = (flit_in[7:6] == MY_X) && (flit_in[5:4] == MY_Y);
  assign misroute = flit_valid_in && flit_ready_out && !addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count   <= 8'h00;
      err_misroute <= 1'b0;
    end else begin
      err_misroute <= misroute;
      if (misroute && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end
`else
  logic addr_unused;

  assign addr_ok     = 1'b1;
  assign addr_unused = ^{flit_in[7:4], MY_X, MY_Y};
`endif
endmodule

// File: tb/tb_noc_local_ni.sv
// tb/tb_noc_local_ni.sv - scoreboard bench for noc_local_ni (both NI_RX_ADDR_CHECK_EN builds)

module tb_noc_local_ni;
  localparam logic [1:0] MY_X = 2'd1;
  localparam logic [1:0] MY_Y = 2'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] tx_dest_x, tx_dest_y;
  logic [3:0] tx_payload;
  logic       tx_valid, tx_ready;
  logic [7:0] flit_out;
  logic       flit_valid_out, flit_ready_in;
  logic [7:0] flit_in;
  logic       flit_valid_in, flit_ready_out;
  logic [3:0] rx_payload;
  logic       rx_valid, rx_ready;
  logic [2:0] tx_count, rx_count;
`ifdef NI_RX_ADDR_CHECK_EN
  logic [7:0] drop_count;
  logic       err_misroute;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] tx_q[$];
  logic [3:0] rx_q[$];

  noc_local_ni #(.MY_X(MY_X), .MY_Y(MY_Y), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_dest_x      (tx_dest_x),
    .tx_dest_y      (tx_dest_y),
    .tx_payload     (tx_payload),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .flit_out       (flit_out),
    .flit_valid_out (flit_valid_out),
    .flit_ready_in  (flit_ready_in),
    .flit_in        (flit_in),
    .flit_valid_in  (flit_valid_in),
    .flit_ready_out (flit_ready_out),
    .rx_payload     (rx_payload),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_count       (tx_count),
    .rx_count       (rx_count)
`ifdef NI_RX_ADDR_CHECK_EN
    ,
    .drop_count     (drop_count),
    .err_misroute   (err_misroute)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every output handshake against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (flit_valid_out && flit_ready_in) begin
        if (tx_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL tx_unexpected: got flit %0h expected none", flit_out);
        end else chk("tx_flit", flit_out, tx_q.pop_front());
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rx_unexpected: got payload %0h expected none", rx_payload);
        end else chk("rx_payload", rx_payload, rx_q.pop_front());
      end
    end
  end

  task automatic send_tx(input logic [1:0] dx, input logic [1:0] dy, input logic [3:0] p);
    tx_dest_x = dx; tx_dest_y = dy; tx_payload = p; tx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (tx_ready) begin
        tx_q.push_back({dx, dy, p});
        tick();
        tx_valid = 1'b0;
        return;
      end
      tick();
    end
    tx_valid = 1'b0;
    vectors++; miscompares++;
    $display("FAIL tx_timeout: got tx_ready=0 expected 1 within 50 cycles");
  endtask

  task automatic send_rx(input logic [7:0] f);
    flit_in = f; flit_valid_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (flit_ready_out) begin
`ifdef NI_RX_ADDR_CHECK_EN
        if (f[7:6] == MY_X && f[5:4] == MY_Y) rx_q.push_back(f[3:0]);
`else
        rx_q.push_back(f[3:0]);
`endif
        tick();
        flit_valid_in = 1'b0;
        return;
      end
      tick();
    end
    flit_valid_in = 1'b0;
    vectors++; miscompares++;
    $display("FAIL rx_timeout: got flit_ready_out=0 expected 1 within 50 cycles");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_dest_x = '0; tx_dest_y = '0; tx_payload = '0;
    flit_ready_in = 1'b0; flit_in = '0; flit_valid_in = 1'b0; rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_flit_valid_out", flit_valid_out, 0);
    chk("rst_flit_out", flit_out, 8'h00);
    chk("rst_flit_ready_out", flit_ready_out, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_payload", rx_payload, 4'h0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
`ifdef NI_RX_ADDR_CHECK_EN
    chk("rst_drop_count", drop_count, 0);
    chk("rst_err_misroute", err_misroute, 0);
`endif

    // TX single: dest (2,1) payload F -> 8'b10_01_1111
    flit_ready_in = 1'b1;
    send_tx(2'd2, 2'd1, 4'hF);
    chk("tx1_valid", flit_valid_out, 1);
    chk("tx1_flit", flit_out, 8'h9F);
    chk("tx1_count", tx_count, 1);
    tick();
    chk("tx1_count_after", tx_count, 0);

    // TX throughput incl. self-addressed flit
    send_tx(2'd1, 2'd1, 4'h3);
    send_tx(2'd3, 2'd0, 4'h6);
    chk("txs_count", tx_count, 1);
    send_tx(2'd0, 2'd2, 4'h9);
    chk("txs_count2", tx_count, 1);
    tick();
    chk("txs_drained", tx_count, 0);

    // TX backpressure
    flit_ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) send_tx(2'd0, 2'd1, 4'(i));
    chk("txb_count_full", tx_count, 4);
    chk("txb_ready_full", tx_ready, 0);
    chk("txb_head", flit_out, 8'h11);
    tx_dest_x = 2'd0; tx_dest_y = 2'd1; tx_payload = 4'h5; tx_valid = 1'b1;
    tick();
    chk("txb_refused_count", tx_count, 4);
    chk("txb_head_stable", flit_out, 8'h11);
    flit_ready_in = 1'b1;
    tick();
    chk("txb_no_bypass", tx_count, 3);
    chk("txb_ready_again", tx_ready, 1);
    tx_q.push_back(8'h15);
    tick();
    tx_valid = 1'b0;
    chk("txb_push_pop", tx_count, 3);
    repeat (3) tick();
    chk("txb_drained", tx_count, 0);

    // RX latency
    send_rx(8'h57);
    chk("rx1_valid", rx_valid, 1);
    chk("rx1_payload", rx_payload, 4'h7);
    rx_ready = 1'b1;
    tick();
    chk("rx1_count_after", rx_count, 0);

    // RX fill/drain
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_rx(8'h5A + 8'(i));
    chk("rxf_ready_full", flit_ready_out, 0);
    chk("rxf_count", rx_count, 4);
    chk("rxf_head", rx_payload, 4'hA);
    rx_ready = 1'b1;
    tick();
    chk("rxf_one_pop", rx_count, 3);
    repeat (3) tick();
    chk("rxf_drained", rx_count, 0);
    chk("rxf_valid_low", rx_valid, 0);
    chk("rxf_payload_zero", rx_payload, 4'h0);

    // Misaddressed flit 8'b10_00_0101
    rx_ready = 1'b0;
    send_rx(8'h85);
`ifdef NI_RX_ADDR_CHECK_EN
    chk("mis_rx_valid", rx_valid, 0);
    chk("mis_drop_count", drop_count, 1);
    chk("mis_err_pulse", err_misroute, 1);
    tick();
    chk("mis_err_clear", err_misroute, 0);
    for (int i = 0; i < 299; i++) send_rx(8'h85);
    chk("mis_drop_sat", drop_count, 8'hFF);
    chk("mis_rx_count", rx_count, 0);
`else
    chk("noflt_rx_count", rx_count, 1);
    chk("noflt_payload", rx_payload, 4'h5);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
`endif

    // Reset mid-operation
    flit_ready_in = 1'b0; rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_tx(2'd3, 2'd3, 4'(i + 8));
    send_rx(8'h51);
    send_rx(8'h52);
    chk("mid_tx_count", tx_count, 3);
    chk("mid_rx_count", rx_count, 2);
    rst = 1'b1;
    tx_q.delete();
    rx_q.delete();
    tick();
    rst = 1'b0;
    chk("mid_tx_count0", tx_count, 0);
    chk("mid_rx_count0", rx_count, 0);
    chk("mid_flit_valid", flit_valid_out, 0);
    chk("mid_rx_valid", rx_valid, 0);
    chk("mid_flit_out", flit_out, 8'h00);
    flit_ready_in = 1'b1; rx_ready = 1'b1;
    repeat (5) tick();
    chk("mid_no_stale_tx", flit_valid_out, 0);
    chk("mid_no_stale_rx", rx_valid, 0);

    chk("end_tx_q_empty", tx_q.size(), 0);
    chk("end_rx_q_empty", rx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
